// File: rtl/prbs13_checker.sv
// Self-synchronising checker for the x^13 + x^12 + x^11 + x^8 + 1 PRBS.
// Once locked it flywheels on its own prediction and counts received bits and bit errors.
module prbs13_checker #(
    parameter int unsigned LOCK_COUNT  = 32,
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned LOSS_THRESH = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             locked,
    output logic             bit_err,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    localparam logic [7:0]       LOCK_LIM = 8'(LOCK_COUNT);
    localparam logic [7:0]       WIN_LIM  = 8'(WINDOW);
    localparam logic [7:0]       LOSS_LIM = 8'(LOSS_THRESH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [12:0]      s_q, s_d;
    logic [3:0]       fill_q, fill_d;
    logic [7:0]       match_q, match_d;
    logic [7:0]       win_cnt_q, win_cnt_d;
    logic [7:0]       win_err_q, win_err_d;
    logic             bit_err_q, bit_err_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             pred;
    logic             mismatch;
    logic [7:0]       win_err_inc;

    assign pred     = s_q[12] ^ s_q[11] ^ s_q[10] ^ s_q[7];
    assign mismatch = in_bit != pred;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        bit_err_d   = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        err_cnt_d   = err_cnt_q;
        win_err_inc = win_err_q + {7'd0, mismatch};

        if (in_valid) begin
            case (state_q)
                SEARCH: begin
                    s_d    = {s_q[11:0], in_bit};
                    fill_d = fill_q + 4'd1;
                    if (fill_q == 4'd12) begin
                        state_d = VERIFY;
                        fill_d  = 4'd0;
                        match_d = 8'd0;
                    end
                end
                VERIFY: begin
                    // An all-zero register predicts zero forever, so it must never count as a match
                    s_d = {s_q[11:0], in_bit};
                    if (!mismatch && (s_q != 13'd0)) begin
                        if (match_q + 8'd1 == LOCK_LIM) begin
                            state_d   = LOCKED;
                            match_d   = 8'd0;
                            win_cnt_d = 8'd0;
                            win_err_d = 8'd0;
                        end else begin
                            match_d = match_q + 8'd1;
                        end
                    end else begin
                        match_d = 8'd0;
                    end
                end
                LOCKED: begin
                    // Flywheel on the prediction so a received error never enters the register
                    s_d = {s_q[11:0], pred};
                    if (bit_cnt_q != '1) begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                    if (mismatch) begin
                        bit_err_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + CNT_ONE;
                        end
                    end
                    if (win_err_inc == LOSS_LIM) begin
                        state_d   = SEARCH;
                        fill_d    = 4'd0;
                        match_d   = 8'd0;
                        win_cnt_d = 8'd0;
                        win_err_d = 8'd0;
                    end else if (win_cnt_q + 8'd1 == WIN_LIM) begin
                        win_cnt_d = 8'd0;
                        win_err_d = 8'd0;
                    end else begin
                        win_cnt_d = win_cnt_q + 8'd1;
                        win_err_d = win_err_inc;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    fill_d  = 4'd0;
                    match_d = 8'd0;
                end
            endcase
        end

        if (clear) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= SEARCH;
            s_q       <= 13'd0;
            fill_q    <= 4'd0;
            match_q   <= 8'd0;
            win_cnt_q <= 8'd0;
            win_err_q <= 8'd0;
            bit_err_q <= 1'b0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            bit_err_q <= bit_err_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign bit_err   = bit_err_q;
    assign bit_count = bit_cnt_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs13_checker.sv
// Self-checking bench for prbs13_checker: PRBS stimulus with random gaps and flips,
// compared against a bit-history reference model and hand-derived constants.
module tb_prbs13_checker;

    localparam int LOCK_COUNT  = 32;
    localparam int WINDOW      = 64;
    localparam int LOSS_THRESH = 8;
    localparam int M_SEARCH    = 0;
    localparam int M_VERIFY    = 1;
    localparam int M_LOCKED    = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_bit;
    logic        clear;
    logic        locked;
    logic        bit_err;
    logic [31:0] bit_count;
    logic [31:0] err_count;
    logic        locked4;
    logic        bit_err4;
    logic [3:0]  bit_count4;
    logic [3:0]  err_count4;

    int          errors;
    int          checks;
    logic [12:0] gen;

    int          mMode;
    int          mFill;
    int          mRun;
    int          mWinPos;
    int          mWinErr;
    bit          hist[$];
    logic        mLocked;
    logic        mBitErr;
    int unsigned mBits;
    int unsigned mErrs;

    prbs13_checker #(.LOCK_COUNT(LOCK_COUNT), .WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
        .locked(locked), .bit_err(bit_err), .bit_count(bit_count), .err_count(err_count)
    );

    prbs13_checker #(.LOCK_COUNT(LOCK_COUNT), .WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
        .locked(locked4), .bit_err(bit_err4), .bit_count(bit_count4), .err_count(err_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: keeps the last 13 bits as a queue, oldest first, and applies the recurrence
    // b[n] = b[n-13] ^ b[n-12] ^ b[n-11] ^ b[n-8] on that history.
    task automatic modelUpdate(input logic v, input logic b, input logic clr, input logic rn);
        logic pred;
        bit   any;
        mBitErr = 1'b0;
        if (!rn) begin
            mMode = M_SEARCH; hist.delete(); mFill = 0; mRun = 0;
            mWinPos = 0; mWinErr = 0; mBits = 0; mErrs = 0;
        end else begin
            if (v) begin
                pred = 1'b0;
                if (hist.size() == 13) pred = hist[0] ^ hist[1] ^ hist[2] ^ hist[5];
                any = 1'b0;
                foreach (hist[i]) any = any | hist[i];
                if (mMode == M_SEARCH) begin
                    hist.push_back(b);
                    mFill++;
                    if (mFill == 13) begin mMode = M_VERIFY; mRun = 0; end
                end else if (mMode == M_VERIFY) begin
                    if (b == pred && any) begin
                        mRun++;
                        if (mRun == LOCK_COUNT) begin mMode = M_LOCKED; mWinPos = 0; mWinErr = 0; end
                    end else begin
                        mRun = 0;
                    end
                    hist.push_back(b);
                end else begin
                    hist.push_back(pred);
                    mBits++;
                    if (b != pred) begin mErrs++; mBitErr = 1'b1; mWinErr++; end
                    mWinPos++;
                    if (mWinErr == LOSS_THRESH) begin
                        mMode = M_SEARCH; mFill = 0; mRun = 0;
                    end else if (mWinPos == WINDOW) begin
                        mWinPos = 0; mWinErr = 0;
                    end
                end
                if (hist.size() > 13) void'(hist.pop_front());
            end
            if (clr) begin mBits = 0; mErrs = 0; end
        end
        mLocked = (mMode == M_LOCKED);
    endtask

    task automatic nextBit(output logic b);
        b   = gen[12] ^ gen[11] ^ gen[10] ^ gen[7];
        gen = {gen[11:0], b};
    endtask

    task automatic step(input logic v, input logic b, input logic clr, input logic rn);
        in_valid = v; in_bit = b; clear = clr; rst_n = rn;
        @(posedge clk);
        modelUpdate(v, b, clr, rn);
        #1;
    endtask

    task automatic sendUntilLocked(output int n);
        logic b;
        n = 0;
        while (locked !== 1'b1 && n < 200) begin
            nextBit(b);
            step(1'b1, b, 1'b0, 1'b1);
            n++;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked got=%b want=0", locked); end
        checks++; if (bit_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_bit_err got=%b want=0", bit_err); end
        checks++; if (bit_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_bit_count got=%0d want=0", bit_count); end
        checks++; if (err_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_err_count got=%0d want=0", err_count); end
        checks++; if (bit_count4 !== 4'd0) begin errors++; $display("[TB] FAIL reset_bit_count4 got=%0d want=0", bit_count4); end
    endtask

    task automatic test_acquire(input bit gapped);
        logic       v, b;
        logic [3:0] sat;
        int         n, lockAt, pulses, lockOff;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n = 0; lockAt = 0; pulses = 0; lockOff = 0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (lockAt != 0 && n >= lockAt + 1000) break;
            v = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
            b = 1'b0;
            if (v) nextBit(b);
            step(v, b, 1'b0, 1'b1);
            if (v) n++;
            sat = (mBits > 15) ? 4'd15 : 4'(mBits);
            checks++; if (locked !== mLocked) begin errors++; $display("[TB] FAIL acq_locked bit=%0d got=%b want=%b", n, locked, mLocked); end
            checks++; if (bit_err !== mBitErr) begin errors++; $display("[TB] FAIL acq_bit_err bit=%0d got=%b want=%b", n, bit_err, mBitErr); end
            checks++; if (bit_count !== mBits) begin errors++; $display("[TB] FAIL acq_bit_count bit=%0d got=%0d want=%0d", n, bit_count, mBits); end
            checks++; if (bit_count4 !== sat) begin errors++; $display("[TB] FAIL acq_bit_count4 bit=%0d got=%0d want=%0d", n, bit_count4, sat); end
            if (bit_err === 1'b1) pulses++;
            if (lockAt == 0 && locked === 1'b1) lockAt = n;
            if (lockAt != 0 && locked !== 1'b1) lockOff++;
        end
        checks++; if (lockAt != 45) begin errors++; $display("[TB] FAIL acq_lock_point gapped=%0d got=%0d want=45", gapped, lockAt); end
        checks++; if (bit_count !== 32'd1000) begin errors++; $display("[TB] FAIL acq_final_bits got=%0d want=1000", bit_count); end
        checks++; if (err_count !== 32'd0) begin errors++; $display("[TB] FAIL acq_final_errs got=%0d want=0", err_count); end
        checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL acq_pulses got=%0d want=0", pulses); end
        checks++; if (lockOff != 0) begin errors++; $display("[TB] FAIL acq_lock_drop got=%0d want=0", lockOff); end
        checks++; if (bit_count4 !== 4'd15) begin errors++; $display("[TB] FAIL acq_sat4 got=%0d want=15", bit_count4); end
    endtask

    task automatic test_single_error();
        logic b, flip;
        int   flipAt, startBits;
        flipAt    = $urandom_range(5, 30);
        startBits = int'(bit_count);
        for (int k = 0; k < flipAt + 100; k++) begin
            nextBit(b);
            flip = (k == flipAt);
            step(1'b1, b ^ flip, 1'b0, 1'b1);
            checks++; if (bit_err !== flip) begin errors++; $display("[TB] FAIL single_bit_err k=%0d got=%b want=%b", k, bit_err, flip); end
            checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL single_locked k=%0d got=%b want=1", k, locked); end
            if (k == flipAt) begin
                checks++; if (err_count !== 32'd1) begin errors++; $display("[TB] FAIL single_err_count got=%0d want=1", err_count); end
            end
        end
        checks++; if (err_count !== 32'd1) begin errors++; $display("[TB] FAIL single_err_final got=%0d want=1", err_count); end
        checks++; if (bit_count !== 32'(startBits + flipAt + 100)) begin errors++; $display("[TB] FAIL single_bits got=%0d want=%0d", bit_count, startBits + flipAt + 100); end
    endtask

    task automatic test_zero_stream();
        int lockSeen, pulses;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        lockSeen = 0; pulses = 0;
        for (int k = 0; k < 500; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            if (locked !== 1'b0) lockSeen++;
            if (bit_err !== 1'b0) pulses++;
        end
        checks++; if (lockSeen != 0) begin errors++; $display("[TB] FAIL zero_locked got=%0d want=0", lockSeen); end
        checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL zero_pulses got=%0d want=0", pulses); end
        checks++; if (bit_count !== 32'd0) begin errors++; $display("[TB] FAIL zero_bits got=%0d want=0", bit_count); end
        checks++; if (err_count !== 32'd0) begin errors++; $display("[TB] FAIL zero_errs got=%0d want=0", err_count); end
    endtask

    task automatic test_clear();
        logic b;
        for (int k = 0; k < 5; k++) begin
            nextBit(b);
            step(1'b1, b, 1'b0, 1'b1);
        end
        nextBit(b);
        step(1'b1, ~b, 1'b1, 1'b1);
        checks++; if (err_count !== 32'd0) begin errors++; $display("[TB] FAIL clear_errs got=%0d want=0", err_count); end
        checks++; if (bit_count !== 32'd0) begin errors++; $display("[TB] FAIL clear_bits got=%0d want=0", bit_count); end
        checks++; if (bit_err !== 1'b1) begin errors++; $display("[TB] FAIL clear_bit_err got=%b want=1", bit_err); end
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL clear_locked got=%b want=1", locked); end
        nextBit(b);
        step(1'b1, b, 1'b0, 1'b1);
        checks++; if (bit_count !== 32'd1) begin errors++; $display("[TB] FAIL clear_next_bits got=%0d want=1", bit_count); end
        checks++; if (bit_err !== 1'b0) begin errors++; $display("[TB] FAIL clear_next_bit_err got=%b want=0", bit_err); end
    endtask

    task automatic test_loss();
        logic b, flip;
        int   n, base, flips, pulses, w;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        sendUntilLocked(n);
        checks++; if (n != 45) begin errors++; $display("[TB] FAIL loss_first_lock got=%0d want=45", n); end
        base = $urandom_range(0, 20);
        flips = 0;
        for (int k = 0; k < WINDOW && flips < LOSS_THRESH; k++) begin
            nextBit(b);
            flip = (k >= base) && ((k - base) % 5 == 0);
            step(1'b1, b ^ flip, 1'b0, 1'b1);
            if (flip) flips++;
            checks++; if (bit_err !== flip) begin errors++; $display("[TB] FAIL loss_bit_err k=%0d got=%b want=%b", k, bit_err, flip); end
            checks++; if (locked !== (flips < LOSS_THRESH)) begin errors++; $display("[TB] FAIL loss_locked k=%0d got=%b want=%b", k, locked, flips < LOSS_THRESH); end
        end
        checks++; if (err_count !== 32'd8) begin errors++; $display("[TB] FAIL loss_errs got=%0d want=8", err_count); end
        checks++; if (bit_count !== 32'(base + 36)) begin errors++; $display("[TB] FAIL loss_bits got=%0d want=%0d", bit_count, base + 36); end
        sendUntilLocked(n);
        checks++; if (n != 45) begin errors++; $display("[TB] FAIL loss_relock got=%0d want=45", n); end
        checks++; if (err_count !== 32'd8) begin errors++; $display("[TB] FAIL loss_relock_errs got=%0d want=8", err_count); end
        checks++; if (bit_count !== 32'(base + 36)) begin errors++; $display("[TB] FAIL loss_relock_bits got=%0d want=%0d", bit_count, base + 36); end
        pulses = 0;
        for (int k = 0; k < 4 * WINDOW; k++) begin
            nextBit(b);
            w = k % WINDOW;
            flip = (w % 9 == 3) && (w < 63);
            step(1'b1, b ^ flip, 1'b0, 1'b1);
            if (bit_err === 1'b1) pulses++;
            checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL hold_locked k=%0d got=%b want=1", k, locked); end
        end
        checks++; if (pulses != 28) begin errors++; $display("[TB] FAIL hold_pulses got=%0d want=28", pulses); end
        checks++; if (err_count !== 32'd36) begin errors++; $display("[TB] FAIL hold_errs got=%0d want=36", err_count); end
        checks++; if (err_count !== mErrs) begin errors++; $display("[TB] FAIL hold_errs_model got=%0d want=%0d", err_count, mErrs); end
        checks++; if (bit_count !== 32'(base + 36 + 256)) begin errors++; $display("[TB] FAIL hold_bits got=%0d want=%0d", bit_count, base + 292); end
    endtask

    task automatic test_saturation_reset();
        logic b;
        int   n;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        sendUntilLocked(n);
        for (int k = 0; k < 20; k++) begin
            nextBit(b);
            step(1'b1, (k == 19) ? ~b : b, 1'b0, 1'b1);
        end
        checks++; if (bit_count4 !== 4'd15) begin errors++; $display("[TB] FAIL sat_bits4 got=%0d want=15", bit_count4); end
        checks++; if (err_count4 !== 4'd1) begin errors++; $display("[TB] FAIL sat_errs4 got=%0d want=1", err_count4); end
        checks++; if (bit_count !== 32'd20) begin errors++; $display("[TB] FAIL sat_bits32 got=%0d want=20", bit_count); end
        checks++; if (bit_err !== 1'b1) begin errors++; $display("[TB] FAIL sat_bit_err got=%b want=1", bit_err); end
        step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        checks++; if (locked !== 1'b0 || locked4 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_locked got=%b/%b want=0", locked, locked4); end
        checks++; if (bit_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_bit_err got=%b want=0", bit_err); end
        checks++; if (bit_count !== 32'd0 || bit_count4 !== 4'd0) begin errors++; $display("[TB] FAIL midrst_bits got=%0d/%0d want=0", bit_count, bit_count4); end
        checks++; if (err_count !== 32'd0 || err_count4 !== 4'd0) begin errors++; $display("[TB] FAIL midrst_errs got=%0d/%0d want=0", err_count, err_count4); end
        sendUntilLocked(n);
        checks++; if (n != 45) begin errors++; $display("[TB] FAIL midrst_relock got=%0d want=45", n); end
    endtask

    initial begin
        errors = 0; checks = 0; gen = 13'd1;
        rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clear = 1'b0;
        modelUpdate(1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_acquire(1'b0);
        test_single_error();
        test_zero_stream();
        test_acquire(1'b1);
        test_clear();
        test_loss();
        test_saturation_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
